// File: rtl/sprite_scheduler.sv
// sprite_scheduler: walks entity slots each frame, hands valid sprites to the draw engine one at a time
module sprite_scheduler #(
    parameter int NUM_SLOTS = 8,
    parameter int ADDR_W = $clog2(NUM_SLOTS),
    parameter int ID_W = 2,
    parameter int COORD_W = 9,
    parameter logic [ID_W-1:0] EMPTY_ID = {ID_W{1'b1}},
    parameter int RD_LAT = 1,
    parameter int ENG_TIMEOUT = 1024
) (
    input  logic               CLOCK_50,
    input  logic               RESET_H,
    input  logic               RUN_QUEUE,
    input  logic               ENG_DONE,
    input  logic [ADDR_W-1:0]  LAST_SLOT,
    input  logic [ID_W-1:0]    ID_CODE,
    input  logic [COORD_W-1:0] X_COORD,
    input  logic [COORD_W-1:0] Y_COORD,
    output logic               QUEUE_DONE,
    output logic               UPDATE,
    output logic               RUN_ENG,
    output logic [ADDR_W-1:0]  ADDRESS,
    output logic [ID_W-1:0]    SPRITE_ID,
    output logic [COORD_W-1:0] TARGET_X,
    output logic [COORD_W-1:0] TARGET_Y,
    output logic [ADDR_W:0]    DRAWN_CNT,
    output logic               TIMEOUT_ERR
);
    localparam int LAT_W = $clog2(RD_LAT + 1);
    localparam int TO_W = $clog2(ENG_TIMEOUT);
    localparam int CNT_W = ADDR_W + 1;

    typedef enum logic [2:0] {IDLE, LOAD, CHECK, UPD, RUN, DONE} state_t;

    state_t             state;
    logic               rq_q;
    logic [ADDR_W-1:0]  last;
    logic [LAT_W-1:0]   lat_cnt;
    logic [TO_W-1:0]    run_cnt;
    logic               start;
    logic               timed_out;
    logic               go_next;

    assign start = RUN_QUEUE & ~rq_q;
    assign timed_out = run_cnt == TO_W'(ENG_TIMEOUT - 1);
    // leaving a slot: either it is empty or the engine finished / was abandoned
    assign go_next = (state == CHECK && ID_CODE == EMPTY_ID) ||
                     (state == RUN && (ENG_DONE || timed_out));

    // frame sequencer with registered strobes; abort has priority over everything
    always_ff @(posedge CLOCK_50 or posedge RESET_H) begin
        if (RESET_H) begin
            state       <= IDLE;
            rq_q        <= 1'b0;
            last        <= '0;
            lat_cnt     <= '0;
            run_cnt     <= '0;
            QUEUE_DONE  <= 1'b0;
            UPDATE      <= 1'b0;
            RUN_ENG     <= 1'b0;
            ADDRESS     <= '0;
            SPRITE_ID   <= '0;
            TARGET_X    <= '0;
            TARGET_Y    <= '0;
            DRAWN_CNT   <= '0;
            TIMEOUT_ERR <= 1'b0;
        end else begin
            rq_q       <= RUN_QUEUE;
            UPDATE     <= 1'b0;
            QUEUE_DONE <= 1'b0;
            if (state != IDLE && !RUN_QUEUE) begin
                state   <= IDLE;
                RUN_ENG <= 1'b0;
                ADDRESS <= '0;
            end else if (go_next) begin
                RUN_ENG <= 1'b0;
                if (state == RUN) begin
                    if (ENG_DONE) DRAWN_CNT <= DRAWN_CNT + CNT_W'(1);
                    else TIMEOUT_ERR <= 1'b1;
                end
                if (ADDRESS == last) begin
                    state      <= DONE;
                    QUEUE_DONE <= 1'b1;
                end else begin
                    ADDRESS <= ADDRESS + ADDR_W'(1);
                    lat_cnt <= '0;
                    state   <= LOAD;
                end
            end else begin
                case (state)
                    IDLE: if (start) begin
                        ADDRESS     <= '0;
                        DRAWN_CNT   <= '0;
                        TIMEOUT_ERR <= 1'b0;
                        last        <= (int'(LAST_SLOT) > NUM_SLOTS - 1) ? ADDR_W'(NUM_SLOTS - 1) : LAST_SLOT;
                        lat_cnt     <= '0;
                        state       <= LOAD;
                    end
                    LOAD: if (lat_cnt == LAT_W'(RD_LAT - 1)) state <= CHECK;
                          else lat_cnt <= lat_cnt + LAT_W'(1);
                    CHECK: begin
                        SPRITE_ID <= ID_CODE;
                        TARGET_X  <= X_COORD;
                        TARGET_Y  <= Y_COORD;
                        UPDATE    <= 1'b1;
                        state     <= UPD;
                    end
                    UPD: begin
                        RUN_ENG <= 1'b1;
                        run_cnt <= '0;
                        state   <= RUN;
                    end
                    RUN: run_cnt <= run_cnt + TO_W'(1);
                    DONE: begin
                        ADDRESS <= '0;
                        state   <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sprite_scheduler.sv
// tb_sprite_scheduler: scoreboard bench with a frame-level reference model and a pipelined register-file model
module tb_sprite_scheduler;
    localparam int NS = 8, AW = 3, IW = 2, CW = 9, LAT = 2, TO = 16;
    localparam logic [IW-1:0] EMPTY = 2'b11;

    logic clk = 0, rst = 0, rq = 0, eng_done = 0;
    logic [AW-1:0] last_slot = 0;
    logic [IW-1:0] id_code;
    logic [CW-1:0] x_coord, y_coord;
    logic queue_done, update, run_eng, terr;
    logic [AW-1:0] address;
    logic [IW-1:0] sprite_id;
    logic [CW-1:0] tx, ty;
    logic [AW:0] drawn;

    logic [IW-1:0] mem_id[NS];
    logic [CW-1:0] mem_x[NS], mem_y[NS];
    int delay[NS];
    logic [AW-1:0] pipe[LAT];

    typedef struct {bit is_done; int addr, id, x, y, run_len, cnt; bit err;} ev_t;
    ev_t sb[$];
    int checks = 0, errors = 0;
    bit cut = 0;

    sprite_scheduler #(.NUM_SLOTS(NS), .RD_LAT(LAT), .ENG_TIMEOUT(TO)) dut (
        .CLOCK_50(clk), .RESET_H(rst), .RUN_QUEUE(rq), .ENG_DONE(eng_done),
        .LAST_SLOT(last_slot), .ID_CODE(id_code), .X_COORD(x_coord), .Y_COORD(y_coord),
        .QUEUE_DONE(queue_done), .UPDATE(update), .RUN_ENG(run_eng), .ADDRESS(address),
        .SPRITE_ID(sprite_id), .TARGET_X(tx), .TARGET_Y(ty), .DRAWN_CNT(drawn), .TIMEOUT_ERR(terr));

    always #5 clk = ~clk;

    // register file with LAT cycles of read latency
    always @(posedge clk) begin
        pipe[0] <= address;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign id_code = mem_id[pipe[LAT-1]];
    assign x_coord = mem_x[pipe[LAT-1]];
    assign y_coord = mem_y[pipe[LAT-1]];

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // engine model: answers after delay[slot] RUN cycles, random noise outside RUN
    initial begin
        int k = 0;
        forever begin
            @(negedge clk);
            if (run_eng) begin
                eng_done = (k == delay[address]);
                k++;
            end else begin
                k = 0;
                eng_done = 1'($urandom_range(0, 1));
            end
        end
    end

    // monitor: pops expected events when the DUT strobes UPDATE or QUEUE_DONE
    initial begin
        int run_cnt = 0, exp_run = 0, prev_addr = 0;
        bit ok;
        ev_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                run_cnt = 0;
                prev_addr = 0;
                continue;
            end
            if (int'(address) != prev_addr && address != 0) chk("addr_step", address, prev_addr + 1);
            prev_addr = address;
            if (update | run_eng | queue_done)
                chk("strobe_exclusive", int'(update) + int'(run_eng) + int'(queue_done), 1);
            if (update) begin
                ok = sb.size() > 0 && !sb[0].is_done;
                chk("update_expected", ok, 1);
                if (ok) begin
                    e = sb.pop_front();
                    chk("upd_addr", address, e.addr);
                    chk("upd_id", sprite_id, e.id);
                    chk("upd_x", tx, e.x);
                    chk("upd_y", ty, e.y);
                    exp_run = e.run_len;
                end
            end
            if (queue_done) begin
                ok = sb.size() > 0 && sb[0].is_done;
                chk("done_expected", ok, 1);
                if (ok) begin
                    e = sb.pop_front();
                    chk("done_cnt", drawn, e.cnt);
                    chk("done_err", terr, e.err);
                end
            end
            if (run_eng) run_cnt++;
            else begin
                if (run_cnt > 0 && !cut) chk("run_len", run_cnt, exp_run);
                run_cnt = 0;
            end
        end
    end

    // reference: every non-empty slot up to last is drawn in order; abort/reset cut the list short
    task automatic run_frame(int last, int abort_slot, bit use_reset);
        ev_t e;
        int cnt = 0, maxa = 0, cyc = 0;
        bit err = 0;
        cut = 0;
        for (int s = 0; s <= last; s++) begin
            if (mem_id[s] != EMPTY) begin
                e = '{0, s, int'(mem_id[s]), int'(mem_x[s]), int'(mem_y[s]),
                      (delay[s] < TO) ? delay[s] + 1 : TO, 0, 0};
                sb.push_back(e);
                if (delay[s] < TO) cnt++;
                else err = 1;
                if (s == abort_slot) break;
            end
        end
        if (abort_slot < 0) begin
            e = '{1, 0, 0, 0, 0, 0, cnt, err};
            sb.push_back(e);
        end
        @(negedge clk);
        rq = 0;
        last_slot = AW'(last);
        @(negedge clk);
        rq = 1;
        if (abort_slot < 0) begin
            while (sb.size() > 0 && cyc < 3000) begin
                @(negedge clk);
                if (int'(address) > maxa) maxa = address;
                cyc++;
            end
            chk("frame_complete", sb.size(), 0);
            chk("max_addr", maxa, last);
            @(negedge clk);
            chk("idle_addr", address, 0);
            chk("drawn_hold", drawn, cnt);
            chk("err_hold", terr, err);
        end else begin
            while (!(run_eng && int'(address) == abort_slot) && cyc < 3000) begin
                @(negedge clk);
                cyc++;
            end
            chk("reached_abort_slot", run_eng && int'(address) == abort_slot, 1);
            repeat (3) @(negedge clk);
            cut = 1;
            if (!use_reset) begin
                rq = 0;
                @(negedge clk);
                chk("abort_outputs", {queue_done, update, run_eng, address}, 0);
                chk("abort_sb_drained", sb.size(), 0);
            end else begin
                #1 rst = 1;
                #1 chk("async_reset_outputs", {queue_done, update, run_eng, address, sprite_id, tx, ty, drawn, terr}, 0);
                chk("reset_sb_drained", sb.size(), 0);
                @(negedge clk);
                rq = 0;
                rst = 0;
                repeat (5) @(negedge clk);
                chk("post_reset_idle", {queue_done, update, run_eng, address}, 0);
            end
        end
    endtask

    task automatic fill(int n_valid);
        for (int s = 0; s < NS; s++) begin
            mem_id[s] = (s < n_valid) ? IW'($urandom_range(0, 2)) : EMPTY;
            mem_x[s] = CW'($urandom);
            mem_y[s] = CW'($urandom);
            delay[s] = $urandom_range(0, 4);
        end
    endtask

    initial begin
        int picks[8] = '{0, 1, 2, 5, 14, 15, 16, 99};
        int act;
        fill(0);
        #1 rst = 1;
        #2 chk("reset_state", {queue_done, update, run_eng, address, sprite_id, tx, ty, drawn, terr}, 0);
        @(negedge clk);
        @(negedge clk) rst = 0;

        fill(0);
        mem_id[0] = 0; mem_x[0] = 10; mem_y[0] = 20;
        mem_id[1] = 1; mem_x[1] = 30; mem_y[1] = 40;
        mem_id[2] = 2; mem_x[2] = 50; mem_y[2] = 60;
        for (int s = 0; s < NS; s++) delay[s] = 5;
        run_frame(3, -1, 0);

        fill(0);
        run_frame(7, -1, 0);

        fill(3);
        delay[1] = 99;
        run_frame(2, -1, 0);

        fill(8);
        delay[2] = 99;
        run_frame(7, 2, 0);
        delay[2] = 3;
        run_frame(7, -1, 0);

        fill(1);
        run_frame(0, -1, 0);
        act = 0;
        repeat (100) begin
            @(negedge clk);
            if (update | run_eng | queue_done | (address != 0)) act++;
        end
        chk("no_retrigger", act, 0);

        fill(4);
        delay[1] = 99;
        run_frame(3, 1, 1);

        repeat (15) begin
            for (int s = 0; s < NS; s++) begin
                mem_id[s] = IW'($urandom_range(0, 3));
                mem_x[s] = CW'($urandom);
                mem_y[s] = CW'($urandom);
                delay[s] = picks[$urandom_range(0, 7)];
            end
            run_frame($urandom_range(0, NS - 1), -1, 0);
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
